boot_copier: RTL and testbench

- Sits between `top_core` and the `rom`/`ram` pair.
- After reset it holds the core in reset and copies the initialised-data image from instruction ROM (byte offset SRC_BASE) into data RAM (byte offset 0), one word per cycle.
- It then releases the core and becomes a transparent pass-through on the ROM address and RAM ports.
- It replaces the force-based start-up copy with synthesizable hardware.

---
 rtl/boot_copier_if.sv | 42 ++++
 rtl/boot_copier.sv | 112 +++++++++++
 tb/tb_boot_copier.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/boot_copier_if.sv
// boot_copier_if
//   Bundles the core-side instruction/data buses and the ROM/RAM-side buses
//   that boot_copier sits between.
//   slave  : view used by boot_copier (takes core requests and memory read
//            data, drives memory requests and data returned to the core).
//   master : opposite view, used by whatever surrounds the copier.
//   Signals:
//     core_inst_addr / core_inst_data : core instruction fetch
//     core_mem_addr / core_mem_wdata / core_mem_we / core_mem_out : core data access
//     rom_addr / rom_data             : synchronous instruction ROM
//     ram_addr / ram_wdata / ram_we / ram_out : data RAM
interface boot_copier_if #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 14
);
  logic [AWIDTH-1:0] core_inst_addr;
  logic [XLEN-1:0]   core_inst_data;
  logic [AWIDTH-1:0] core_mem_addr;
  logic [XLEN-1:0]   core_mem_wdata;
  logic [2:0]        core_mem_we;
  logic [XLEN-1:0]   core_mem_out;
  logic [AWIDTH-1:0] rom_addr;
  logic [XLEN-1:0]   rom_data;
  logic [AWIDTH-1:0] ram_addr;
  logic [XLEN-1:0]   ram_wdata;
  logic [2:0]        ram_we;
  logic [XLEN-1:0]   ram_out;

  modport slave (
    input  core_inst_addr, core_mem_addr, core_mem_wdata, core_mem_we,
    input  rom_data, ram_out,
    output core_inst_data, core_mem_out,
    output rom_addr, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output core_inst_addr, core_mem_addr, core_mem_wdata, core_mem_we,
    output rom_data, ram_out,
    input  core_inst_data, core_mem_out,
    input  rom_addr, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/boot_copier.sv
// boot_copier
//   After reset (or a reboot pulse) holds the core in reset and copies
//   COPY_BYTES of initialised data from the instruction ROM at SRC_BASE into
//   data RAM starting at address 0, one word per cycle. When the copy is
//   complete the core is released and the block becomes a transparent
//   pass-through between the core and the ROM/RAM.
//   Ports:
//     clk        : system clock
//     rst_n      : asynchronous active-low reset
//     reboot     : single-cycle pulse, honoured only once boot is done
//     core_rst_n : registered active-low reset to the core
//     boot_done  : high once the copy has completed
//     bus        : core/ROM/RAM buses (boot_copier_if, slave view)
module boot_copier #(
  parameter int                XLEN       = 32,
  parameter int                AWIDTH     = 14,
  parameter logic [AWIDTH-1:0] SRC_BASE   = 'h800,
  parameter int                COPY_BYTES = 2**AWIDTH,
  parameter logic [2:0]        WE_WORD    = 3'b110
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reboot,
  output logic          core_rst_n,
  output logic          boot_done,
  boot_copier_if.slave  bus
);

  typedef enum logic [1:0] {COPY, DRAIN, RELEASE, DONE} state_t;

  // Read counter is one bit wider than the address so that a full
  // 2**AWIDTH-byte copy reaches its last word without wrapping to zero.
  localparam int                LAST_RD_I = COPY_BYTES - 4;
  localparam logic [AWIDTH:0]   LAST_RD   = LAST_RD_I[AWIDTH:0];
  localparam logic [AWIDTH:0]   RD_STEP   = {{(AWIDTH-2){1'b0}}, 3'd4};

  state_t            state;
  logic [AWIDTH:0]   rd_cnt;
  // Write address: the read offset delayed by one cycle, matching the
  // one-cycle latency of the synchronous ROM.
  logic [AWIDTH-1:0] wr_cnt;
  logic              wr_valid;

  // Copy sequencer. Each COPY cycle issues one ROM read; the matching RAM
  // write follows a cycle later. DRAIN lets the final write land, RELEASE
  // lifts the core reset, DONE waits for a reboot request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COPY;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      wr_valid   <= 1'b0;
      core_rst_n <= 1'b0;
      boot_done  <= 1'b0;
    end else begin
      case (state)
        COPY: begin
          rd_cnt   <= rd_cnt + RD_STEP;
          wr_cnt   <= rd_cnt[AWIDTH-1:0];
          wr_valid <= 1'b1;
          if (rd_cnt == LAST_RD) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          wr_valid <= 1'b0;
          state    <= RELEASE;
        end
        RELEASE: begin
          core_rst_n <= 1'b1;
          boot_done  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (reboot) begin
            state      <= COPY;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            wr_valid   <= 1'b0;
            core_rst_n <= 1'b0;
            boot_done  <= 1'b0;
          end
        end
        default: begin
          state <= COPY;
        end
      endcase
    end
  end

  // Bus steering. While copying, the ROM address follows the read counter
  // and then holds the last issued address; ROM data is written straight
  // into RAM whenever a delayed write is pending, and the core sees zeros.
  // In DONE every bus is passed straight through.
  always_comb begin
    bus.rom_addr       = SRC_BASE + ((state == COPY) ? rd_cnt[AWIDTH-1:0] : wr_cnt);
    bus.core_inst_data = {XLEN{1'b0}};
    bus.core_mem_out   = {XLEN{1'b0}};
    bus.ram_addr       = wr_cnt;
    bus.ram_wdata      = bus.rom_data;
    bus.ram_we         = wr_valid ? WE_WORD : 3'b000;
    if (state == DONE) begin
      bus.rom_addr       = bus.core_inst_addr;
      bus.core_inst_data = bus.rom_data;
      bus.ram_addr       = bus.core_mem_addr;
      bus.ram_wdata      = bus.core_mem_wdata;
      bus.ram_we         = bus.core_mem_we;
      bus.core_mem_out   = bus.ram_out;
    end
  end

endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier
//   Directed bench for boot_copier. Two copies of the design are built:
//   dut_a copies a 16-byte image, dut_b a single word. Each has its own
//   ROM/RAM models. ROM word i holds C000_0000|i except the image words at
//   byte 'h800..'h80C, which hold A000_0000..A000_0003.
module tb_boot_copier;

  logic clk;
  logic rst_n_a, rst_n_b;
  logic reboot_a, reboot_b;
  logic core_rst_n_a, core_rst_n_b;
  logic boot_done_a, boot_done_b;
  logic fill_a, fill_b;

  int n_checks;
  int n_fail;

  logic [31:0] rom_mem [0:4095];
  logic [31:0] ram_a   [0:4095];
  logic [31:0] ram_b   [0:4095];

  boot_copier_if #(.XLEN(32), .AWIDTH(14)) bus_a ();
  boot_copier_if #(.XLEN(32), .AWIDTH(14)) bus_b ();

  boot_copier #(.XLEN(32), .AWIDTH(14), .SRC_BASE(14'h800), .COPY_BYTES(16), .WE_WORD(3'b110)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n_a),
    .reboot     (reboot_a),
    .core_rst_n (core_rst_n_a),
    .boot_done  (boot_done_a),
    .bus        (bus_a)
  );

  boot_copier #(.XLEN(32), .AWIDTH(14), .SRC_BASE(14'h800), .COPY_BYTES(4), .WE_WORD(3'b110)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n_b),
    .reboot     (reboot_b),
    .core_rst_n (core_rst_n_b),
    .boot_done  (boot_done_b),
    .bus        (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 32'hC000_0000 | 32'(i);
    for (int i = 0; i < 4; i++) rom_mem[512 + i] = 32'hA000_0000 + 32'(i);
  end

  // Synchronous ROMs, one per DUT.
  always_ff @(posedge clk) bus_a.rom_data <= rom_mem[bus_a.rom_addr[13:2]];
  always_ff @(posedge clk) bus_b.rom_data <= rom_mem[bus_b.rom_addr[13:2]];

  // RAMs: full-word write on WE 110, asynchronous read, bulk fill on request.
  always_ff @(posedge clk) begin
    if (fill_a) begin
      for (int i = 0; i < 4096; i++) ram_a[i] <= 32'h5A5A_0000 + 32'(i);
    end else if (bus_a.ram_we == 3'b110) begin
      ram_a[bus_a.ram_addr[13:2]] <= bus_a.ram_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (fill_b) begin
      for (int i = 0; i < 4096; i++) ram_b[i] <= 32'h5A5A_0000 + 32'(i);
    end else if (bus_b.ram_we == 3'b110) begin
      ram_b[bus_b.ram_addr[13:2]] <= bus_b.ram_wdata;
    end
  end
  assign bus_a.ram_out = ram_a[bus_a.ram_addr[13:2]];
  assign bus_b.ram_out = ram_b[bus_b.ram_addr[13:2]];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Holds both designs in reset, fills RAMs, and checks reset outputs while
  // the core side tries to write.
  task automatic applyStimulus_reset();
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    reboot_a = 1'b0; reboot_b = 1'b0;
    fill_a = 1'b1; fill_b = 1'b1;
    bus_a.core_inst_addr = '0; bus_a.core_mem_addr = '0;
    bus_a.core_mem_wdata = 32'h5555_5555; bus_a.core_mem_we = 3'b110;
    bus_b.core_inst_addr = '0; bus_b.core_mem_addr = '0;
    bus_b.core_mem_wdata = 32'h5555_5555; bus_b.core_mem_we = 3'b110;
    @(posedge clk); #1;
    fill_a = 1'b0; fill_b = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus_reset();
    n_checks++; if (core_rst_n_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_core_rst_n_a: got %b expected 0", core_rst_n_a); end
    n_checks++; if (boot_done_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_boot_done_a: got %b expected 0", boot_done_a); end
    n_checks++; if (bus_a.ram_we !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_ram_we_a: got %b expected 000", bus_a.ram_we); end
    n_checks++; if (bus_a.core_inst_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_core_inst_data_a: got %h expected 0", bus_a.core_inst_data); end
    n_checks++; if (bus_a.core_mem_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_core_mem_out_a: got %h expected 0", bus_a.core_mem_out); end
    n_checks++; if (bus_a.rom_addr !== 14'h800) begin n_fail++; $display("[TB] FAIL reset_rom_addr_a: got %h expected 800", bus_a.rom_addr); end
    n_checks++; if (core_rst_n_b !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_core_rst_n_b: got %b expected 0", core_rst_n_b); end
    n_checks++; if (bus_b.ram_we !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_ram_we_b: got %b expected 000", bus_b.ram_we); end
  endtask

  // Runs one 16-byte copy on dut_a, starting with the next clock edge as
  // edge 1, and checks every cycle plus the final RAM image. A reboot pulse
  // is applied on edge reboot_at+1 (0 = none) and must have no effect.
  task automatic checkOutput_copy16(input int reboot_at);
    logic [31:0] exp_data;
    logic [13:0] exp_addr;
    logic [13:0] exp_rom;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      reboot_a = (k == reboot_at);
      if (k <= 4) begin
        exp_data = 32'hA000_0000 + 32'(k - 1);
        exp_addr = 14'(4 * (k - 1));
        exp_rom  = (k < 4) ? 14'(32'h800 + 32'(4 * k)) : 14'h80C;
        n_checks++; if (bus_a.ram_we !== 3'b110) begin n_fail++; $display("[TB] FAIL copy_we edge %0d: got %b expected 110", k, bus_a.ram_we); end
        n_checks++; if (bus_a.ram_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL copy_addr edge %0d: got %h expected %h", k, bus_a.ram_addr, exp_addr); end
        n_checks++; if (bus_a.ram_wdata !== exp_data) begin n_fail++; $display("[TB] FAIL copy_wdata edge %0d: got %h expected %h", k, bus_a.ram_wdata, exp_data); end
        n_checks++; if (bus_a.rom_addr !== exp_rom) begin n_fail++; $display("[TB] FAIL copy_rom_addr edge %0d: got %h expected %h", k, bus_a.rom_addr, exp_rom); end
        n_checks++; if (core_rst_n_a !== 1'b0) begin n_fail++; $display("[TB] FAIL copy_core_rst_n edge %0d: got %b expected 0", k, core_rst_n_a); end
        n_checks++; if (bus_a.core_mem_out !== 32'h0) begin n_fail++; $display("[TB] FAIL copy_core_mem_out edge %0d: got %h expected 0", k, bus_a.core_mem_out); end
      end else if (k == 5) begin
        n_checks++; if (bus_a.ram_we !== 3'b000) begin n_fail++; $display("[TB] FAIL release_we: got %b expected 000", bus_a.ram_we); end
        n_checks++; if (core_rst_n_a !== 1'b0) begin n_fail++; $display("[TB] FAIL release_core_rst_n: got %b expected 0", core_rst_n_a); end
        n_checks++; if (boot_done_a !== 1'b0) begin n_fail++; $display("[TB] FAIL release_boot_done: got %b expected 0", boot_done_a); end
      end else begin
        n_checks++; if (core_rst_n_a !== 1'b1) begin n_fail++; $display("[TB] FAIL done_core_rst_n: got %b expected 1", core_rst_n_a); end
        n_checks++; if (boot_done_a !== 1'b1) begin n_fail++; $display("[TB] FAIL done_boot_done: got %b expected 1", boot_done_a); end
        bus_a.core_mem_we = 3'b000;
      end
    end
    reboot_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ram_a[i] !== 32'hA000_0000 + 32'(i)) begin
        n_fail++; $display("[TB] FAIL image_word %0d: got %h expected %h", i, ram_a[i], 32'hA000_0000 + 32'(i));
      end
    end
    n_checks++; if (ram_a[4] !== 32'h5A5A_0004) begin n_fail++; $display("[TB] FAIL image_beyond: got %h expected 5a5a0004", ram_a[4]); end
  endtask

  // 16-byte copy from reset while the core tries to write address 0.
  task automatic test_copy16();
    bus_a.core_mem_addr = 14'h0; bus_a.core_mem_wdata = 32'h5555_5555; bus_a.core_mem_we = 3'b110;
    @(negedge clk); rst_n_a = 1'b1;
    checkOutput_copy16(0);
  endtask

  // Single-word copy: COPY lasts one cycle.
  task automatic test_copy4();
    @(negedge clk); rst_n_b = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus_b.ram_we !== 3'b110) begin n_fail++; $display("[TB] FAIL w1_we: got %b expected 110", bus_b.ram_we); end
    n_checks++; if (bus_b.ram_addr !== 14'h0) begin n_fail++; $display("[TB] FAIL w1_addr: got %h expected 0", bus_b.ram_addr); end
    n_checks++; if (bus_b.ram_wdata !== 32'hA000_0000) begin n_fail++; $display("[TB] FAIL w1_wdata: got %h expected a0000000", bus_b.ram_wdata); end
    @(posedge clk); #1;
    n_checks++; if (bus_b.ram_we !== 3'b000) begin n_fail++; $display("[TB] FAIL w1_release_we: got %b expected 000", bus_b.ram_we); end
    n_checks++; if (core_rst_n_b !== 1'b0) begin n_fail++; $display("[TB] FAIL w1_release_core_rst_n: got %b expected 0", core_rst_n_b); end
    @(posedge clk); #1;
    n_checks++; if (core_rst_n_b !== 1'b1) begin n_fail++; $display("[TB] FAIL w1_core_rst_n: got %b expected 1", core_rst_n_b); end
    n_checks++; if (boot_done_b !== 1'b1) begin n_fail++; $display("[TB] FAIL w1_boot_done: got %b expected 1", boot_done_b); end
    bus_b.core_mem_we = 3'b000;
    n_checks++; if (ram_b[0] !== 32'hA000_0000) begin n_fail++; $display("[TB] FAIL w1_ram0: got %h expected a0000000", ram_b[0]); end
    n_checks++; if (ram_b[1] !== 32'h5A5A_0001) begin n_fail++; $display("[TB] FAIL w1_ram1: got %h expected 5a5a0001", ram_b[1]); end
  endtask

  // Core traffic reaches ROM/RAM unchanged once boot is done.
  task automatic test_passthrough();
    bus_a.core_mem_addr = 14'h10; bus_a.core_mem_wdata = 32'hDEAD_BEEF;
    bus_a.core_mem_we = 3'b110; bus_a.core_inst_addr = 14'h40;
    #1;
    n_checks++; if (bus_a.ram_addr !== 14'h10) begin n_fail++; $display("[TB] FAIL pass_ram_addr: got %h expected 10", bus_a.ram_addr); end
    n_checks++; if (bus_a.ram_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL pass_ram_wdata: got %h expected deadbeef", bus_a.ram_wdata); end
    n_checks++; if (bus_a.ram_we !== 3'b110) begin n_fail++; $display("[TB] FAIL pass_ram_we: got %b expected 110", bus_a.ram_we); end
    n_checks++; if (bus_a.rom_addr !== 14'h40) begin n_fail++; $display("[TB] FAIL pass_rom_addr: got %h expected 40", bus_a.rom_addr); end
    @(posedge clk); #1;
    bus_a.core_mem_we = 3'b000;
    n_checks++; if (bus_a.core_inst_data !== 32'hC000_0010) begin n_fail++; $display("[TB] FAIL pass_inst_data: got %h expected c0000010", bus_a.core_inst_data); end
    n_checks++; if (bus_a.core_mem_out !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL pass_mem_out: got %h expected deadbeef", bus_a.core_mem_out); end
    n_checks++; if (ram_a[4] !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL pass_ram_word: got %h expected deadbeef", ram_a[4]); end
  endtask

  // Asynchronous reset after edge 3 of a copy; the copy restarts from word 0.
  task automatic test_reset_midcopy();
    @(negedge clk); rst_n_a = 1'b0; fill_a = 1'b1;
    @(posedge clk); #1; fill_a = 1'b0;
    bus_a.core_mem_addr = 14'h0; bus_a.core_mem_wdata = 32'h5555_5555; bus_a.core_mem_we = 3'b110;
    @(negedge clk); rst_n_a = 1'b1;
    repeat (3) @(posedge clk);
    #2; rst_n_a = 1'b0;
    #1;
    n_checks++; if (bus_a.ram_we !== 3'b000) begin n_fail++; $display("[TB] FAIL abort_ram_we: got %b expected 000", bus_a.ram_we); end
    n_checks++; if (core_rst_n_a !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_core_rst_n: got %b expected 0", core_rst_n_a); end
    n_checks++; if (bus_a.rom_addr !== 14'h800) begin n_fail++; $display("[TB] FAIL abort_rom_addr: got %h expected 800", bus_a.rom_addr); end
    n_checks++; if (ram_a[2] !== 32'h5A5A_0002) begin n_fail++; $display("[TB] FAIL abort_partial: got %h expected 5a5a0002", ram_a[2]); end
    @(negedge clk); rst_n_a = 1'b1;
    checkOutput_copy16(5);
  endtask

  // Reboot in DONE re-runs the full copy; a reboot mid-copy is ignored.
  task automatic test_back_to_back();
    n_checks++; if (core_rst_n_a !== 1'b1) begin n_fail++; $display("[TB] FAIL reboot_in_release_ignored: got %b expected 1", core_rst_n_a); end
    @(posedge clk); #1; fill_a = 1'b1;
    @(posedge clk); #1; fill_a = 1'b0;
    @(negedge clk); reboot_a = 1'b1;
    @(posedge clk); #1;
    reboot_a = 1'b0;
    bus_a.core_mem_addr = 14'h0; bus_a.core_mem_wdata = 32'h5555_5555; bus_a.core_mem_we = 3'b110;
    n_checks++; if (core_rst_n_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reboot_core_rst_n: got %b expected 0", core_rst_n_a); end
    n_checks++; if (boot_done_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reboot_boot_done: got %b expected 0", boot_done_a); end
    n_checks++; if (bus_a.ram_we !== 3'b000) begin n_fail++; $display("[TB] FAIL reboot_ram_we: got %b expected 000", bus_a.ram_we); end
    checkOutput_copy16(2);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_copy16();
    test_copy4();
    test_passthrough();
    test_reset_midcopy();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
